// File: rtl/tt_eval_pkg.sv
// rtl/tt_eval_pkg.sv - shared types, constants and helpers for the truth-table evaluator
// Contents:
//   tt_state_t      : evaluator FSM states (IDLE, SWEEP, DONE)
//   TT_W_MAX        : widest supported truth table (N_IN = 8)
//   TT_INIT_DEFAULT : reset truth table for the 4-input default build
//   tt_w(n)         : truth-table width for an n-input function
package tt_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } tt_state_t;

    localparam int TT_W_MAX = 256;

    localparam logic [15:0] TT_INIT_DEFAULT = 16'h381A;

    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_sweep_eval_mux.sv
// rtl/tt_sweep_eval_mux.sv - combinational TT_W:1 truth-table lookup
// Module tt_lut_mux, shared by the single-evaluation and sweep paths.
// Ports:
//   tt  : truth table, bit i = function value for input index i
//   sel : input index
//   y   : tt[sel]
module tt_lut_mux
    import tt_eval_pkg::*;
#(
    parameter int N_IN = 4,
    localparam int TT_W = tt_w(N_IN)
) (
    input  logic [TT_W-1:0] tt,
    input  logic [N_IN-1:0] sel,
    output logic            y
);

    assign y = tt[sel];

endmodule

// File: rtl/tt_sweep_eval.sv
// rtl/tt_sweep_eval.sv - registered N-input truth-table evaluator with self-check sweep
// Optional feature macro: TT_SWEEP_EN (sweep FSM, index counter, comparator).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   cfg_valid/cfg_ready/cfg_tt      : truth-table reload handshake
//   in_valid/in_ready/in_vec        : evaluation request handshake
//   out_valid/out_ready/out_bit     : evaluation result handshake (1-cycle latency)
//   sweep_start, sweep_expect       : sweep request and golden signature
//   sweep_busy, sweep_done          : sweep in progress / one-cycle completion pulse
//   sweep_match, sweep_sig          : compare result and rebuilt signature
module tt_sweep_eval
    import tt_eval_pkg::*;
#(
    parameter int N_IN = 4,
    localparam int TT_W = tt_w(N_IN),
    parameter logic [TT_W-1:0] TT_INIT = TT_W'(TT_INIT_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [TT_W-1:0] cfg_tt,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    input  logic            sweep_start,
    input  logic [TT_W-1:0] sweep_expect,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic            sweep_match,
    output logic [TT_W-1:0] sweep_sig
);

    logic [TT_W-1:0] tt_q;
    logic [N_IN-1:0] lut_sel;
    logic            lut_y;
    logic            in_accept;
    tt_state_t       state_q;

    assign cfg_ready = (state_q == IDLE);
    assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready);
    assign in_accept = in_valid && in_ready;

    tt_lut_mux #(.N_IN(N_IN)) u_lut_mux (
        .tt  (tt_q),
        .sel (lut_sel),
        .y   (lut_y)
    );

    // The lookup reads tt_q before the load lands, so an evaluation accepted
    // alongside a table load sees the old table.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q      <= TT_INIT;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                tt_q <= cfg_tt;
            end
            if (in_accept) begin
                out_valid <= 1'b1;
                out_bit   <= lut_y;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef TT_SWEEP_EN

    tt_state_t       state_d;
    logic [N_IN-1:0] idx_q;
    logic            idx_last;
    logic            match_q;
    logic            sig_eq;

    assign idx_last = &idx_q;
    assign sig_eq   = (sweep_sig == sweep_expect);
    assign lut_sel  = (state_q == SWEEP) ? idx_q : in_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sweep_start) state_d = SWEEP;
            SWEEP:   if (idx_last)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            sweep_sig <= '0;
            match_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sweep_start) begin
                        idx_q     <= '0;
                        sweep_sig <= '0;
                        match_q   <= 1'b0;
                    end
                end
                SWEEP: begin
                    sweep_sig[idx_q] <= lut_y;
                    // Saturate on the last index rather than wrapping to 0.
                    if (!idx_last) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    match_q <= sig_eq;
                end
                default: ;
            endcase
        end
    end

    assign sweep_busy  = (state_q == SWEEP);
    assign sweep_done  = (state_q == DONE);
    // During DONE the live compare is shown so the result is valid with the pulse.
    assign sweep_match = (state_q == DONE) ? sig_eq : match_q;

`else

    logic unused_sweep;

    assign state_q      = IDLE;
    assign lut_sel      = in_vec;
    assign sweep_busy   = 1'b0;
    assign sweep_done   = 1'b0;
    assign sweep_match  = 1'b0;
    assign sweep_sig    = '0;
    assign unused_sweep = ^{sweep_start, sweep_expect};

`endif

endmodule

// File: tb/tb_tt_sweep_eval.sv
// tb/tb_tt_sweep_eval.sv - directed self-checking bench for tt_sweep_eval
module tb_tt_sweep_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_tt;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_vec;
    logic        out_valid;
    logic        out_ready;
    logic        out_bit;
    logic        sweep_start;
    logic [15:0] sweep_expect;
    logic        sweep_busy;
    logic        sweep_done;
    logic        sweep_match;
    logic [15:0] sweep_sig;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tt_sweep_eval #(.N_IN(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_tt       (cfg_tt),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vec       (in_vec),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bit      (out_bit),
        .sweep_start  (sweep_start),
        .sweep_expect (sweep_expect),
        .sweep_busy   (sweep_busy),
        .sweep_done   (sweep_done),
        .sweep_match  (sweep_match),
        .sweep_sig    (sweep_sig)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eval_vec(input logic [3:0] v, input logic exp, input string tag);
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        step();
        in_valid = 1'b0;
        check({tag, "_out_valid"}, 16'(out_valid), 16'd1);
        check(tag, 16'(out_bit), 16'(exp));
    endtask

`ifdef TT_SWEEP_EN
    task automatic run_sweep(input logic [15:0] expect_w, input logic [15:0] exp_sig,
                             input logic exp_match, input logic do_load,
                             input logic [15:0] load_w, input logic poke, input string tag);
        int busy_n;
        int done_n;
        int done_at;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        sweep_start  = 1'b1;
        sweep_expect = expect_w;
        cfg_valid    = do_load;
        cfg_tt       = load_w;
        step();
        sweep_start = 1'b0;
        cfg_valid   = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (sweep_busy) busy_n++;
            if (sweep_done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k;
                    check({tag, "_match_at_done"}, 16'(sweep_match), 16'(exp_match));
                end
            end
            if (poke) begin
                cfg_valid = sweep_busy;
                cfg_tt    = 16'hFFFF;
                in_valid  = sweep_busy;
                in_vec    = 4'd0;
                #1;
                if (k == 1 || k == 16) begin
                    check({tag, "_cfg_ready_busy"}, 16'(cfg_ready), 16'd0);
                    check({tag, "_in_ready_busy"}, 16'(in_ready), 16'd0);
                end
            end
            step();
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_busy_cycles"}, 16'(busy_n), 16'd16);
        check({tag, "_done_cycle"}, 16'(done_at), 16'd17);
        check({tag, "_done_pulses"}, 16'(done_n), 16'd1);
        check({tag, "_sig"}, sweep_sig, exp_sig);
        check({tag, "_match_held"}, 16'(sweep_match), 16'(exp_match));
    endtask
`endif

    initial begin
        logic [3:0] vecs [4];
        logic       exps [4];
        vecs = '{4'd3, 4'd4, 4'd11, 4'd0};
        exps = '{1'b1, 1'b1, 1'b1, 1'b0};

        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_tt       = 16'h0000;
        in_valid     = 1'b0;
        in_vec       = 4'd0;
        out_ready    = 1'b1;
        sweep_start  = 1'b0;
        sweep_expect = 16'h0000;
        step();
        step();
        rst = 1'b0;
        #1;

        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_bit", 16'(out_bit), 16'd0);
        check("rst_busy", 16'(sweep_busy), 16'd0);
        check("rst_done", 16'(sweep_done), 16'd0);
        check("rst_match", 16'(sweep_match), 16'd0);
        check("rst_sig", sweep_sig, 16'h0000);
        check("rst_cfg_ready", 16'(cfg_ready), 16'd1);
        check("rst_in_ready", 16'(in_ready), 16'd1);

        // Back-to-back evaluations of the default table 0x381A.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_vec = vecs[i];
            #1;
            check("b2b_in_ready", 16'(in_ready), 16'd1);
            step();
            check("b2b_out_valid", 16'(out_valid), 16'd1);
            check($sformatf("b2b_vec%0d", vecs[i]), 16'(out_bit), 16'(exps[i]));
        end
        in_valid = 1'b0;
        step();
        check("drain_out_valid", 16'(out_valid), 16'd0);

        // Backpressure: result for vec 11 (=1) holds while vec 0 (=0) waits.
        in_valid  = 1'b1;
        in_vec    = 4'd11;
        out_ready = 1'b0;
        step();
        in_vec = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 16'(in_ready), 16'd0);
            step();
            check("bp_out_valid", 16'(out_valid), 16'd1);
            check("bp_out_bit_held", 16'(out_bit), 16'd1);
        end
        in_vec    = 4'd1;
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 16'(in_ready), 16'd1);
        step();
        in_valid = 1'b0;
        check("bp_vec1", 16'(out_bit), 16'd1);
        step();

        // Load 0x8000 with a same-cycle evaluation of vec 12 on the old table.
        cfg_valid = 1'b1;
        cfg_tt    = 16'h8000;
        in_valid  = 1'b1;
        in_vec    = 4'd12;
        #1;
        check("load_cfg_ready", 16'(cfg_ready), 16'd1);
        step();
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        check("load_same_cycle_vec12", 16'(out_bit), 16'd1);
        eval_vec(4'd15, 1'b1, "t8000_vec15");
        eval_vec(4'd14, 1'b0, "t8000_vec14");
        eval_vec(4'd12, 1'b0, "t8000_vec12");

        cfg_valid = 1'b1;
        cfg_tt    = 16'h381A;
        step();
        cfg_valid = 1'b0;

`ifdef TT_SWEEP_EN
        run_sweep(16'h381A, 16'h381A, 1'b1, 1'b0, 16'h0000, 1'b1, "sweep_ok");
        run_sweep(16'h381B, 16'h381A, 1'b0, 1'b0, 16'h0000, 1'b0, "sweep_bad");
        run_sweep(16'hA5C3, 16'hA5C3, 1'b1, 1'b1, 16'hA5C3, 1'b0, "sweep_load");
`endif

        // Table 0xFFFF and a stalled pending result, then reset.
        cfg_valid = 1'b1;
        cfg_tt    = 16'hFFFF;
        step();
        cfg_valid = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 4'd6;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("pend_out_bit", 16'(out_bit), 16'd1);

`ifdef TT_SWEEP_EN
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        repeat (6) step();
        check("mid_busy", 16'(sweep_busy), 16'd1);
        check("mid_pending_held", 16'(out_valid), 16'd1);
        check("mid_partial_sig", sweep_sig, 16'h003F);
`else
        begin
            int busy_seen;
            busy_seen   = 0;
            sweep_start = 1'b1;
            sweep_expect = 16'hFFFF;
            step();
            sweep_start = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (sweep_busy || sweep_done || sweep_match) busy_seen++;
                step();
            end
            check("nosweep_busy_done", 16'(busy_seen), 16'd0);
            check("nosweep_sig", sweep_sig, 16'h0000);
            check("nosweep_pending_held", 16'(out_valid), 16'd1);
        end
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_out_valid", 16'(out_valid), 16'd0);
        check("post_rst_out_bit", 16'(out_bit), 16'd0);
        check("post_rst_busy", 16'(sweep_busy), 16'd0);
        check("post_rst_done", 16'(sweep_done), 16'd0);
        check("post_rst_match", 16'(sweep_match), 16'd0);
        check("post_rst_sig", sweep_sig, 16'h0000);
        eval_vec(4'd15, 1'b0, "post_rst_vec15");
        eval_vec(4'd13, 1'b1, "post_rst_vec13");
        eval_vec(4'd2, 1'b0, "post_rst_vec2");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
